// File: rtl/acc_cpu_soc.sv
// acc_cpu_soc: multi-cycle accumulator CPU with loadable program memory,
// data RAM, GPIO register and a back-pressured 8N1 UART transmitter.
module acc_cpu_soc #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int GPIO_W       = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [ADDR_W+3:0] prog_wdata,
  input  logic [GPIO_W-1:0] sw,
  output logic [GPIO_W-1:0] led,
  output logic              uart_tx,
  output logic              tx_busy,
  output logic              halted,
  output logic [DATA_W-1:0] debug_acc,
  output logic [ADDR_W-1:0] debug_pc
);
  localparam int IW    = ADDR_W + 4;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = $clog2(CLKS_PER_BIT);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_IN  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'h9;
  localparam logic [3:0] OP_TX  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IW-1:0]     r_prog [DEPTH];
  logic [DATA_W-1:0] r_ram  [DEPTH];
  logic [IW-1:0]     r_ir;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_acc;
  logic              r_c;
  logic [GPIO_W-1:0] r_led;

  logic              r_busy;
  logic              r_line;
  logic [CW-1:0]     r_cnt;
  logic [3:0]        r_bit;
  logic [8:0]        r_shift;

  logic [3:0]        w_op;
  logic [ADDR_W-1:0] w_a;
  logic [DATA_W-1:0] w_mem;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [7:0]        w_tx_byte;
  logic              w_exec;
  logic              w_tx_req;
  logic              w_stall;
  logic              w_tx_go;
  logic              w_unused_c;

  assign w_op      = r_ir[IW-1 -: 4];
  assign w_a       = r_ir[ADDR_W-1:0];
  assign w_mem     = r_ram[w_a];
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_mem};
  assign w_diff    = {1'b0, r_acc} - {1'b0, w_mem};
  assign w_tx_byte = 8'(r_acc);
  assign w_exec    = (r_state == S_EXEC);
  assign w_tx_req  = w_exec && (w_op == OP_TX);
  assign w_stall   = w_tx_req && r_busy;
  assign w_tx_go   = w_tx_req && !r_busy;

  // Carry has no architectural consumer yet.
  assign w_unused_c = r_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH: w_next = S_EXEC;
      S_EXEC: begin
        if (w_op == OP_HLT) begin
          w_next = S_HALT;
        end else if (!w_stall) begin
          w_next = S_FETCH;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    halted    = (r_state == S_HALT);
    led       = r_led;
    uart_tx   = r_line;
    tx_busy   = r_busy;
    debug_acc = r_acc;
    debug_pc  = r_pc;
  end

  always_ff @(posedge clk) begin
    if (prog_we) begin
      r_prog[prog_addr] <= prog_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_exec && (w_op == OP_STA)) begin
      r_ram[w_a] <= r_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ir  <= '0;
      r_pc  <= '0;
      r_acc <= '0;
      r_c   <= 1'b0;
      r_led <= '0;
    end else if (r_state == S_FETCH) begin
      r_ir <= r_prog[r_pc];
    end else if (w_exec && !w_stall) begin
      r_pc <= r_pc + ADDR_W'(1);
      case (w_op)
        OP_LDA: r_acc <= w_mem;
        OP_ADD: {r_c, r_acc} <= w_sum;
        OP_SUB: {r_c, r_acc} <= w_diff;
        OP_LDI: r_acc <= DATA_W'(w_a);
        OP_JMP: r_pc <= w_a;
        OP_JZ: begin
          if (r_acc == '0) begin
            r_pc <= w_a;
          end
        end
        OP_IN:  r_acc <= DATA_W'(sw);
        OP_OUT: r_led <= GPIO_W'(r_acc);
        OP_HLT: r_pc <= r_pc;
        default: ;
      endcase
    end
  end

  // Shifter holds {stop, data}; the start bit is driven on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_line  <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else if (w_tx_go) begin
      r_busy  <= 1'b1;
      r_line  <= 1'b0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= {1'b1, w_tx_byte};
    end else if (r_busy) begin
      if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
        r_cnt <= '0;
        if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
          r_line <= 1'b1;
        end else begin
          r_line  <= r_shift[0];
          r_shift <= {1'b0, r_shift[8:1]};
          r_bit   <= r_bit + 4'd1;
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule
